// File: rtl/led_shift_sequencer.sv
// ---------------------------------------------------------------------------
// led_shift_sequencer
//   Holds a WIDTH-bit LED pattern and advances it once per accepted tick.
//   The motion mode is chosen by button edges: rotate left, rotate right,
//   bounce, or paused. A one-cycle wrap strobe marks every rotate wrap
//   and every bounce reversal.
//
//   Optional feature macro: LED_SEQ_STEP_COUNT_EN
//     When defined, a saturating 16-bit step_count output counts applied
//     ticks. It is cleared by a pause edge that enters PAUSED.
//
// Ports
//   clock       in   system clock; all state updates on the rising edge
//   reset       in   asynchronous, active-high reset
//   tick        in   one-cycle advance pulse
//   btn_left    in   level; a rising edge selects rotate-left
//   btn_right   in   level; a rising edge selects rotate-right
//   btn_bounce  in   level; a rising edge selects bounce
//   btn_pause   in   level; a rising edge toggles pause
//   leds        out  current pattern (registered)
//   dir         out  0 = moving toward MSB, 1 = moving toward LSB
//   running     out  1 when not paused
//   wrap_pulse  out  one-cycle strobe on a wrap or a bounce reversal
//   step_count  out  applied-tick count (LED_SEQ_STEP_COUNT_EN only)
// ---------------------------------------------------------------------------
module led_shift_sequencer #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_bounce,
    input  logic             btn_pause,
    output logic [WIDTH-1:0] leds,
`ifdef LED_SEQ_STEP_COUNT_EN
    output logic [15:0]      step_count,
`endif
    output logic             dir,
    output logic             running,
    output logic             wrap_pulse
);

    typedef enum logic [2:0] {PAUSED, ROT_L, ROT_R, BNC_L, BNC_R} state_t;

    state_t           state, state_nxt;
    state_t           saved_mode, saved_nxt;
    logic             dir_nxt;
    logic [WIDTH-1:0] leds_nxt;
    logic             wrap_nxt;
    logic [3:0]       btn_q;
    logic             e_left, e_right, e_bounce, e_pause;

    // Each edge is a single-cycle event, even while the button is held.
    assign e_left   = btn_left   & ~btn_q[0];
    assign e_right  = btn_right  & ~btn_q[1];
    assign e_bounce = btn_bounce & ~btn_q[2];
    assign e_pause  = btn_pause  & ~btn_q[3];

    // state is a register, so this decode tracks it with no extra delay.
    assign running = (state != PAUSED);

`ifdef LED_SEQ_STEP_COUNT_EN
    logic [15:0] step_nxt;
`endif

    always_comb begin
        state_nxt = state;
        saved_nxt = saved_mode;
        dir_nxt   = dir;
        leds_nxt  = leds;
        wrap_nxt  = 1'b0;
`ifdef LED_SEQ_STEP_COUNT_EN
        step_nxt  = step_count;
`endif

        // Mode selection. Only the highest-priority edge acts, and the
        // rest are dropped. While paused, mode edges only retarget the
        // mode that the next pause edge resumes.
        if (e_pause) begin
            if (state == PAUSED) begin
                state_nxt = saved_mode;
            end else begin
                saved_nxt = state;
                state_nxt = PAUSED;
`ifdef LED_SEQ_STEP_COUNT_EN
                step_nxt  = '0;
`endif
            end
        end else if (e_bounce) begin
            if (state == PAUSED) saved_nxt = dir ? BNC_R : BNC_L;
            else                 state_nxt = dir ? BNC_R : BNC_L;
        end else if (e_left) begin
            dir_nxt = 1'b0;
            if (state == PAUSED) saved_nxt = ROT_L;
            else                 state_nxt = ROT_L;
        end else if (e_right) begin
            dir_nxt = 1'b1;
            if (state == PAUSED) saved_nxt = ROT_R;
            else                 state_nxt = ROT_R;
        end

        // The tick acts on the mode chosen in this same cycle.
        if (tick && state_nxt != PAUSED) begin
`ifdef LED_SEQ_STEP_COUNT_EN
            if (step_nxt != 16'hFFFF) step_nxt = step_nxt + 16'd1;
`endif
            case (state_nxt)
                ROT_L: begin
                    leds_nxt = {leds[WIDTH-2:0], leds[WIDTH-1]};
                    wrap_nxt = leds[WIDTH-1];
                end
                ROT_R: begin
                    leds_nxt = {leds[0], leds[WIDTH-1:1]};
                    wrap_nxt = leds[0];
                end
                BNC_L: begin
                    // An all-zero pattern would never move, so reseed it.
                    if (leds == '0) begin
                        leds_nxt = SEED;
                    end else if (leds[WIDTH-1]) begin
                        state_nxt = BNC_R;
                        dir_nxt   = 1'b1;
                        leds_nxt  = leds >> 1;
                        wrap_nxt  = 1'b1;
                    end else begin
                        leds_nxt  = leds << 1;
                    end
                end
                BNC_R: begin
                    if (leds == '0) begin
                        leds_nxt = SEED;
                    end else if (leds[0]) begin
                        state_nxt = BNC_L;
                        dir_nxt   = 1'b0;
                        leds_nxt  = leds << 1;
                        wrap_nxt  = 1'b1;
                    end else begin
                        leds_nxt  = leds >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= PAUSED;
            saved_mode <= ROT_L;
            dir        <= 1'b0;
            leds       <= SEED;
            wrap_pulse <= 1'b0;
            btn_q      <= '0;
        end else begin
            state      <= state_nxt;
            saved_mode <= saved_nxt;
            dir        <= dir_nxt;
            leds       <= leds_nxt;
            wrap_pulse <= wrap_nxt;
            btn_q      <= {btn_pause, btn_bounce, btn_right, btn_left};
        end
    end

`ifdef LED_SEQ_STEP_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) step_count <= '0;
        else       step_count <= step_nxt;
    end
`endif

endmodule

// File: tb/tb_led_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_shift_sequencer
//   Directed bench for led_shift_sequencer with WIDTH=8 and SEED=8'h01.
//   A vector table steps through the main modes. Hand-written sequences
//   then cover reset behaviour.
// ---------------------------------------------------------------------------
module tb_led_shift_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       btn_left, btn_right, btn_bounce, btn_pause;
    logic [7:0] leds;
    logic       dir, running, wrap_pulse;
`ifdef LED_SEQ_STEP_COUNT_EN
    logic [15:0] step_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    led_shift_sequencer #(.WIDTH(8), .SEED(8'h01)) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_bounce (btn_bounce),
        .btn_pause  (btn_pause),
        .leds       (leds),
`ifdef LED_SEQ_STEP_COUNT_EN
        .step_count (step_count),
`endif
        .dir        (dir),
        .running    (running),
        .wrap_pulse (wrap_pulse)
    );

    // btn bit order: {pause, bounce, left, right}
    typedef struct {
        logic       tick;
        logic [3:0] btn;
        logic [7:0] leds;
        logic       dir;
        logic       run;
        logic       wrap;
    } vec_t;

    vec_t vq[$];

    task automatic drive(input logic t, input logic [3:0] b);
        tick       = t;
        btn_pause  = b[3];
        btn_bounce = b[2];
        btn_left   = b[1];
        btn_right  = b[0];
    endtask

    task automatic check_out(input string name, input logic [7:0] el,
                             input logic ed, input logic er, input logic ew);
        checks++;
        if (leds !== el || dir !== ed || running !== er || wrap_pulse !== ew) begin
            errors++;
            $display("FAIL %s: got leds=%h dir=%b run=%b wrap=%b, want leds=%h dir=%b run=%b wrap=%b",
                     name, leds, dir, running, wrap_pulse, el, ed, er, ew);
        end
    endtask

    initial begin
        // Five ticks while paused: nothing moves.
        for (int i = 0; i < 5; i++) vq.push_back('{1'b1, 4'h0, 8'h01, 1'b0, 1'b0, 1'b0});
        // The pause edge resumes the reset mode ROT_L. Eight ticks then walk
        // the bit around, with a wrap only on 80->01.
        vq.push_back('{1'b0, 4'h8, 8'h01, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h02, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h04, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h08, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h10, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h20, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h40, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h80, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h01, 1'b0, 1'b1, 1'b1});
        // A right edge with a tick uses the new mode: 01 -> 80, with a wrap.
        vq.push_back('{1'b1, 4'h1, 8'h80, 1'b1, 1'b1, 1'b1});
        vq.push_back('{1'b1, 4'h1, 8'h40, 1'b1, 1'b1, 1'b0});  // held: no new edge
        vq.push_back('{1'b0, 4'h2, 8'h40, 1'b0, 1'b1, 1'b0});  // left sets dir=0
        vq.push_back('{1'b0, 4'h4, 8'h40, 1'b0, 1'b1, 1'b0});  // bounce with dir=0 -> BNC_L
        vq.push_back('{1'b1, 4'h0, 8'h80, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h40, 1'b1, 1'b1, 1'b1});  // reversal
        vq.push_back('{1'b1, 4'h0, 8'h20, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h10, 1'b1, 1'b1, 1'b0});
        // Pause, left and right together: only pause acts, and the tick is ignored.
        vq.push_back('{1'b1, 4'hB, 8'h10, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h10, 1'b1, 1'b0, 1'b0});
        // Resume BNC_R with a tick in the same cycle.
        vq.push_back('{1'b1, 4'h8, 8'h08, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h04, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h02, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h01, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h02, 1'b0, 1'b1, 1'b1});  // LSB reversal
        vq.push_back('{1'b0, 4'h1, 8'h02, 1'b1, 1'b1, 1'b0});  // ROT_R
        vq.push_back('{1'b1, 4'h1, 8'h01, 1'b1, 1'b1, 1'b0});
        // Bounce beats left. With dir=1 this gives BNC_R, which reverses
        // immediately at 01.
        vq.push_back('{1'b1, 4'h7, 8'h02, 1'b0, 1'b1, 1'b1});
        vq.push_back('{1'b1, 4'h7, 8'h04, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h08, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h10, 1'b0, 1'b1, 1'b0});

        reset = 1'b1;
        drive(1'b0, 4'h0);
        repeat (2) @(posedge clock);
        #1 check_out("reset_state", 8'h01, 1'b0, 1'b0, 1'b0);
`ifdef LED_SEQ_STEP_COUNT_EN
        checks++;
        if (step_count !== 16'd0) begin
            errors++;
            $display("FAIL step_reset: got %0d want 0", step_count);
        end
`endif
        @(negedge clock);
        reset = 1'b0;

        foreach (vq[i]) begin
            @(negedge clock);
            drive(vq[i].tick, vq[i].btn);
            @(posedge clock);
            #1 check_out($sformatf("vec%0d", i), vq[i].leds, vq[i].dir, vq[i].run, vq[i].wrap);
        end

`ifdef LED_SEQ_STEP_COUNT_EN
        checks++;
        if (step_count !== 16'd10) begin
            errors++;
            $display("FAIL step_count: got %0d want 10", step_count);
        end
`endif

        // Assert reset between edges during a bounce at leds=10. The outputs
        // must clear before the next clock edge.
        @(negedge clock);
        drive(1'b0, 4'h0);
        #2 reset = 1'b1;
        #1 check_out("async_reset", 8'h01, 1'b0, 1'b0, 1'b0);
`ifdef LED_SEQ_STEP_COUNT_EN
        checks++;
        if (step_count !== 16'd0) begin
            errors++;
            $display("FAIL step_async_reset: got %0d want 0", step_count);
        end
`endif
        // Reset holds even with a tick and every button active.
        @(negedge clock);
        drive(1'b1, 4'hF);
        @(posedge clock);
        #1 check_out("reset_hold", 8'h01, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        drive(1'b0, 4'h0);
        reset = 1'b0;
        // After release, the state is PAUSED and a tick is ignored.
        @(negedge clock);
        drive(1'b1, 4'h0);
        @(posedge clock);
        #1 check_out("post_reset_tick", 8'h01, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_shift_sequencer.md
Name: led_shift_sequencer

Overview:
- Downstream consumer of the programmable tick timer's one-cycle `out` pulse.
- Holds a WIDTH-bit LED pattern and advances it once per accepted tick.
- Motion mode (rotate left, rotate right, bounce, paused) is selected by button inputs through an internal FSM with edge detection.
- Drives board LEDs plus a wrap strobe for downstream status logic.

Parameters:
- WIDTH, 8, number of LED bits; legal range 2 and up.
- SEED, 8'b0000_0001, reset and reload pattern (WIDTH bits).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle advance pulse from the timer's `out`.
- btn_left  input  1  level, pre-synchronized; rising edge selects ROT_L.
- btn_right  input  1  level, pre-synchronized; rising edge selects ROT_R.
- btn_bounce  input  1  level, pre-synchronized; rising edge selects bounce.
- btn_pause  input  1  level, pre-synchronized; rising edge toggles pause.
- leds  output  WIDTH  current pattern (registered).
- dir  output  1  0 = moving left (toward MSB), 1 = moving right.
- running  output  1  1 when not paused.
- wrap_pulse  output  1  one-cycle strobe on wrap or bounce reversal.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - leds = SEED, state = PAUSED, saved_mode = ROT_L, dir = 0.
  - running = 0, wrap_pulse = 0, all button edge registers = 0.
- Edge detection: one register per button; edge = btn & ~btn_q. A button held high produces exactly one edge.
- Priority when several edges occur in the same cycle: pause > bounce > left > right. Only the highest-priority edge acts; the rest are dropped.
- FSM states are PAUSED, ROT_L, ROT_R, BNC_L, BNC_R.
  - Left edge: go to ROT_L, dir = 0.
  - Right edge: go to ROT_R, dir = 1.
  - Bounce edge: go to BNC_L if dir = 0, else BNC_R.
  - Pause edge in a running state: save the current state into saved_mode, go to PAUSED.
  - Pause edge in PAUSED: go to saved_mode.
  - Left/right/bounce edge in PAUSED: update saved_mode and dir only; stay PAUSED.
- running = (state != PAUSED), registered.
- Ticks:
  - A tick is applied only in the running states; in PAUSED, ticks are ignored.
  - A mode change and a tick in the same cycle: the new mode is applied to that tick.
  - Latency: leds changes on the same rising edge at which tick = 1 is sampled.
- Per-tick action by state:
  - ROT_L: leds = {leds[WIDTH-2:0], leds[WIDTH-1]}. wrap_pulse = 1 if the old leds[WIDTH-1] = 1.
  - ROT_R: leds = {leds[0], leds[WIDTH-1:1]}. wrap_pulse = 1 if the old leds[0] = 1.
  - BNC_L, old leds[WIDTH-1] = 1: go to BNC_R, dir = 1, shift right with zero fill, wrap_pulse = 1.
  - BNC_L otherwise: shift left with zero fill.
  - BNC_R: mirror of BNC_L, using leds[0].
- In bounce states, if leds == 0 when a tick arrives, load SEED instead of shifting; no wrap_pulse.
- wrap_pulse is high for exactly one cycle and never high without a tick in the same cycle.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously), regardless of tick or button activity.

Optional Feature:
- Macro: LED_SEQ_STEP_COUNT_EN.
- Defined:
  - Adds output step_count[15:0], reset to 0.
  - Increments on every applied tick (ticks ignored in PAUSED are not counted).
  - Saturates at 16'hFFFF.
  - Cleared by a rising edge on btn_pause that enters PAUSED.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8, SEED=8'h01):
- Reset release, 5 ticks with no buttons -> leds stays 8'h01, running = 0, wrap_pulse never 1.
- Pause edge, then 8 ticks -> leds steps 02, 04, …, 80, then 01; wrap_pulse high only on the 80→01 tick.
- Right edge coincident with a tick while leds = 8'h01 -> same edge gives leds = 8'h80, dir = 1, wrap_pulse = 1.
- Bounce edge at leds = 8'h40, dir = 0, then 3 ticks -> 80, 40 (dir = 1, wrap_pulse = 1), 20.
- Pause, left, and right edges in the same cycle while running -> only pause acts: state PAUSED, dir unchanged; the next pause edge resumes the previous mode.
- Reset asserted between clock edges during bounce at leds = 8'h10 -> leds = 8'h01 and running = 0 before the next clock edge; with LED_SEQ_STEP_COUNT_EN defined, step_count = 0.
